// File: rtl/stage_decode_param.sv
// stage_decode_param: ID stage with a built-in register file, writeback bypass and a
// one-cycle bubble on load-use hazards against a load sitting in ID.
module stage_decode_param #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int NWB     = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic [NWB-1:0]      wb_en,
    input  logic [NWB*8-1:0]    wb_rw,
    input  logic [NWB*XLEN-1:0] wb_data,
    input  logic                if_valid,
    input  logic [31:0]         if_instr,
    input  logic [31:0]         if_pc,
    output logic                id_valid,
    output logic [7:0]          id_op,
    output logic [7:0]          id_rw,
    output logic [7:0]          id_r1,
    output logic [7:0]          id_r2,
    output logic [15:0]         id_imm,
    output logic [XLEN-1:0]     id_v1,
    output logic [XLEN-1:0]     id_v2,
    output logic [31:0]         id_pc,
    output logic                hazard_stall
);
    localparam int RW = $clog2(NREGS);
    localparam logic [7:0] OP_ADD = 8'h01, OP_SUB = 8'h02, OP_AND = 8'h03,
                           OP_WRL = 8'h10, OP_RDL = 8'h11;

    logic [XLEN-1:0] rf [NREGS];
    logic [7:0]      op, rw, r1, r2;
    logic            reg_src;
    logic [XLEN-1:0] v1, v2;

    assign {op, rw, r1, r2} = if_instr;
    assign reg_src = op inside {OP_ADD, OP_SUB, OP_AND, OP_WRL, OP_RDL};

    // Later writeback ports override earlier ones; r0 forcing overrides everything.
    function automatic logic [XLEN-1:0] read(input logic [7:0] r);
        logic [XLEN-1:0] v;
        v = rf[r[RW-1:0]];
        for (int i = 0; i < NWB; i++)
            if (wb_en[i] && wb_rw[8*i +: RW] == r[RW-1:0])
                v = wb_data[XLEN*i +: XLEN];
        return (ZERO_R0 != 0 && r[RW-1:0] == '0) ? '0 : v;
    endfunction

    assign v1 = reg_src ? read(r1) : XLEN'(r1);
    assign v2 = reg_src ? read(r2) : XLEN'(r2);

    assign hazard_stall = !reset && if_valid && id_valid && id_op == OP_RDL && reg_src
        && (id_rw[RW-1:0] == r1[RW-1:0] || id_rw[RW-1:0] == r2[RW-1:0])
        && !(ZERO_R0 != 0 && id_rw[RW-1:0] == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NREGS; k++)
                rf[k] <= '0;
        end else begin
            for (int i = 0; i < NWB; i++)
                if (wb_en[i] && !(ZERO_R0 != 0 && wb_rw[8*i +: RW] == '0))
                    rf[wb_rw[8*i +: RW]] <= wb_data[XLEN*i +: XLEN];
        end
    end

    always_ff @(posedge clock) begin
        if (reset || (!stall && (flush || hazard_stall))) begin
            {id_valid, id_op, id_rw, id_r1, id_r2, id_imm, id_v1, id_v2, id_pc} <= '0;
        end else if (!stall) begin
            id_valid <= if_valid;
            id_op    <= op;
            id_rw    <= rw;
            id_r1    <= r1;
            id_r2    <= r2;
            id_imm   <= if_instr[15:0];
            id_v1    <= v1;
            id_v2    <= v2;
            id_pc    <= if_pc;
        end
    end
endmodule

// File: tb/tb_stage_decode_param.sv
// tb_stage_decode_param: directed and random stimulus on two configurations
// (32 regs with hard r0, 16 regs with writable r0) against a behavioural model.
module tb_stage_decode_param;
    localparam logic [7:0] ADD = 8'h01, SUB = 8'h02, AND_ = 8'h03, WRL = 8'h10, RDL = 8'h11;

    typedef struct packed {
        logic        v;
        logic [7:0]  op, rw, r1, r2;
        logic [15:0] imm;
        logic [31:0] v1, v2, pc;
    } id_t;

    logic        clock = 0, reset = 1, stall = 0, flush = 0, if_valid = 0;
    logic [1:0]  wb_en = 0;
    logic [15:0] wb_rw = 0;
    logic [63:0] wb_data = 0;
    logic [31:0] if_instr = 0, if_pc = 0;
    logic        h0, h1;
    id_t         g0, g1;
    int          checks = 0, errors = 0;
    id_t         m_id [2];
    logic [31:0] m_rf [2][32];

    always #5 clock = ~clock;

    stage_decode_param #(.XLEN(32), .NREGS(32), .NWB(2), .ZERO_R0(1)) dut0 (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush), .wb_en(wb_en),
        .wb_rw(wb_rw), .wb_data(wb_data), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .id_valid(g0.v), .id_op(g0.op), .id_rw(g0.rw), .id_r1(g0.r1),
        .id_r2(g0.r2), .id_imm(g0.imm), .id_v1(g0.v1), .id_v2(g0.v2), .id_pc(g0.pc),
        .hazard_stall(h0));

    stage_decode_param #(.XLEN(32), .NREGS(16), .NWB(2), .ZERO_R0(0)) dut1 (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush), .wb_en(wb_en),
        .wb_rw(wb_rw), .wb_data(wb_data), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .id_valid(g1.v), .id_op(g1.op), .id_rw(g1.rw), .id_r1(g1.r1),
        .id_r2(g1.r2), .id_imm(g1.imm), .id_v1(g1.v1), .id_v2(g1.v2), .id_pc(g1.pc),
        .hazard_stall(h1));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int nr(input int d);
        return d ? 16 : 32;
    endfunction

    function automatic bit is_reg(input logic [7:0] op);
        return op == ADD || op == SUB || op == AND_ || op == WRL || op == RDL;
    endfunction

    function automatic logic [31:0] mread(input int d, input logic [7:0] r);
        int a = int'(r) % nr(d);
        logic [31:0] v = m_rf[d][a];
        for (int i = 0; i < 2; i++)
            if (wb_en[i] && int'(wb_rw[8*i +: 8]) % nr(d) == a) v = wb_data[32*i +: 32];
        return (d == 0 && a == 0) ? 32'h0 : v;
    endfunction

    function automatic logic mhaz(input int d);
        int a = int'(m_id[d].rw) % nr(d);
        if (reset || !if_valid || !m_id[d].v || m_id[d].op != RDL || !is_reg(if_instr[31:24]))
            return 1'b0;
        if (d == 0 && a == 0) return 1'b0;
        return a == int'(if_instr[15:8]) % nr(d) || a == int'(if_instr[7:0]) % nr(d);
    endfunction

    function automatic id_t mnext(input int d);
        id_t n;
        logic [7:0] op, r1, r2;
        {op, r1, r2} = {if_instr[31:24], if_instr[15:8], if_instr[7:0]};
        if (reset || (!stall && (flush || mhaz(d)))) return '0;
        if (stall) return m_id[d];
        n.v = if_valid; n.op = op; n.rw = if_instr[23:16]; n.r1 = r1; n.r2 = r2;
        n.imm = if_instr[15:0]; n.pc = if_pc;
        n.v1 = is_reg(op) ? mread(d, r1) : {24'h0, r1};
        n.v2 = is_reg(op) ? mread(d, r2) : {24'h0, r2};
        return n;
    endfunction

    task automatic mwrite(input int d);
        for (int k = 0; k < 32; k++)
            if (reset) m_rf[d][k] = '0;
        if (!reset)
            for (int i = 0; i < 2; i++)
                if (wb_en[i]) m_rf[d][int'(wb_rw[8*i +: 8]) % nr(d)] = wb_data[32*i +: 32];
    endtask

    task automatic cmp(input int d, input id_t g);
        check($sformatf("d%0d valid", d), 64'(g.v), 64'(m_id[d].v));
        check($sformatf("d%0d op", d), 64'(g.op), 64'(m_id[d].op));
        check($sformatf("d%0d rw", d), 64'(g.rw), 64'(m_id[d].rw));
        check($sformatf("d%0d r1", d), 64'(g.r1), 64'(m_id[d].r1));
        check($sformatf("d%0d r2", d), 64'(g.r2), 64'(m_id[d].r2));
        check($sformatf("d%0d imm", d), 64'(g.imm), 64'(m_id[d].imm));
        check($sformatf("d%0d v1", d), 64'(g.v1), 64'(m_id[d].v1));
        check($sformatf("d%0d v2", d), 64'(g.v2), 64'(m_id[d].v2));
        check($sformatf("d%0d pc", d), 64'(g.pc), 64'(m_id[d].pc));
    endtask

    task automatic cycle();
        id_t n [2];
        #1;
        check("hazard d0", 64'(h0), 64'(mhaz(0)));
        check("hazard d1", 64'(h1), 64'(mhaz(1)));
        for (int d = 0; d < 2; d++) n[d] = mnext(d);
        @(posedge clock);
        for (int d = 0; d < 2; d++) begin
            mwrite(d);
            m_id[d] = n[d];
        end
        #1;
        cmp(0, g0);
        cmp(1, g1);
    endtask

    task automatic set(input logic [7:0] op, rw, r1, r2);
        if_instr = {op, rw, r1, r2};
        if_valid = 1;
        if_pc = if_pc + 4;
    endtask

    function automatic logic [7:0] ridx();
        logic [7:0] r = 8'($urandom_range(0, 5));
        if ($urandom_range(0, 3) == 0) r = r | 8'(16 << $urandom_range(0, 3));
        return r;
    endfunction

    initial begin
        logic [7:0] ops [6];
        ops = '{ADD, SUB, AND_, WRL, RDL, RDL};
        for (int d = 0; d < 2; d++) m_id[d] = '0;
        set(ADD, 8'd1, 8'd2, 8'd3);
        cycle();
        cycle();
        check("reset valid", 64'(g0.v), 64'h0);
        check("reset op", 64'(g0.op), 64'h0);
        check("reset pc", 64'(g0.pc), 64'h0);
        reset = 0;
        set(ADD, 0, 5, 5);
        cycle();
        check("reset r5", 64'(g0.v1), 64'h0);
        wb_en = 2'b01; wb_rw = 16'h0003; wb_data = 64'h11;
        set(ADD, 0, 3, 0);
        cycle();
        check("bypass v1", 64'(g0.v1), 64'h11);
        wb_en = 2'b11; wb_rw = 16'h0303; wb_data = {32'h22, 32'h11};
        cycle();
        check("bypass prio", 64'(g0.v1), 64'h22);
        wb_en = 0;
        cycle();
        check("rf prio", 64'(g0.v1), 64'h22);
        set(8'h40, 0, 8'h12, 8'h34);
        cycle();
        check("imm v1", 64'(g0.v1), 64'h12);
        check("imm v2", 64'(g0.v2), 64'h34);
        check("imm imm", 64'(g0.imm), 64'h1234);
        set(RDL, 4, 0, 0);
        cycle();
        set(ADD, 0, 0, 4);
        #1 check("loaduse haz", 64'(h0), 64'h1);
        cycle();
        check("loaduse bubble", 64'(g0.v), 64'h0);
        cycle();
        check("loaduse issue", 64'(g0.v), 64'h1);
        check("loaduse r2", 64'(g0.r2), 64'h4);
        set(RDL, 0, 0, 0);
        cycle();
        set(ADD, 0, 0, 0);
        #1 check("r0 haz d0", 64'(h0), 64'h0);
        check("r0 haz d1", 64'(h1), 64'h1);
        cycle();
        set(SUB, 7, 1, 2);
        cycle();
        stall = 1; flush = 1;
        wb_en = 2'b01; wb_rw = 16'h0009; wb_data = 64'hABCD;
        set(ADD, 0, 0, 0);
        cycle();
        check("stall hold", 64'(g0.op), 64'(SUB));
        stall = 0; wb_en = 0;
        cycle();
        check("flush bubble", 64'(g0.v), 64'h0);
        flush = 0;
        set(ADD, 0, 9, 0);
        cycle();
        check("stall wb", 64'(g0.v1), 64'hABCD);
        wb_en = 2'b01; wb_rw = 16'h0011; wb_data = 64'h77;
        set(8'h40, 0, 0, 0);
        cycle();
        wb_en = 0;
        set(ADD, 0, 1, 17);
        cycle();
        check("mod16 r1", 64'(g1.v1), 64'h77);
        check("r17 d0", 64'(g0.v2), 64'h77);
        wb_en = 2'b01; wb_rw = 16'h0000; wb_data = 64'h55;
        set(8'h40, 0, 0, 0);
        cycle();
        wb_en = 0;
        set(ADD, 0, 0, 0);
        cycle();
        check("r0 d1", 64'(g1.v1), 64'h55);
        check("r0 d0", 64'(g0.v1), 64'h0);
        for (int c = 0; c < 600; c++) begin
            reset = $urandom_range(0, 63) == 0;
            stall = $urandom_range(0, 7) == 0;
            flush = $urandom_range(0, 7) == 0;
            wb_en = 2'($urandom);
            wb_rw = {ridx(), ridx()};
            wb_data = {$urandom, $urandom};
            if_valid = $urandom_range(0, 7) != 0;
            if_instr = {($urandom_range(0, 6) == 6) ? 8'($urandom) : ops[$urandom_range(0, 5)],
                        ridx(), ridx(), ridx()};
            if_pc = $urandom;
            cycle();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
